// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder.
// Takes one word request through a valid/ready handshake, waits WAIT_CYCLES
// cycles, performs the access on the edge that enters RESP, and returns a
// single-cycle response. Define DMEM_RESP_ERR_EN to flag misaligned and
// out-of-range addresses; otherwise resp_err is 0 and addresses wrap.
module dmem_responder #(
   parameter int ADDR_WIDTH  = 8,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        req_ready,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   // The counter is 4 bits wide; anything outside 0..15 cannot be represented.
   // The index slice also needs at least one address bit above it.
   generate
      if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
         $error("dmem_responder: WAIT_CYCLES must be in 0..15");
      end
      if (ADDR_WIDTH < 1 || ADDR_WIDTH > 29) begin : g_bad_addr
         $error("dmem_responder: ADDR_WIDTH must be in 1..29");
      end
   endgenerate

   localparam logic [3:0] WAIT_VAL = 4'(WAIT_CYCLES);
   localparam int         DEPTH    = 1 << ADDR_WIDTH;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t                  r_state;
   state_t                  w_state_next;
   logic [3:0]              r_cnt;
   logic                    r_write;
   logic [ADDR_WIDTH-1:0]   r_idx;
   logic [31:0]             r_wdata;
   logic [31:0]             r_rdata;
   logic [31:0]             r_mem [DEPTH];

   logic                    w_accept;
   logic                    w_enter_resp;
   logic                    w_acc_write;
   logic [ADDR_WIDTH-1:0]   w_acc_idx;
   logic [31:0]             w_acc_wdata;
   logic                    w_acc_err;
   logic                    w_mem_we;
   logic [ADDR_WIDTH-1:0]   w_req_idx;

   assign w_req_idx = req_addr[ADDR_WIDTH+1:2];

   // With zero wait states the access happens on the acceptance edge itself,
   // before anything is latched, so the access operands come straight from the
   // request port in that case and from the latched copy otherwise.
   assign w_acc_write = w_accept ? req_write : r_write;
   assign w_acc_idx   = w_accept ? w_req_idx : r_idx;
   assign w_acc_wdata = w_accept ? req_wdata : r_wdata;

`ifdef DMEM_RESP_ERR_EN
   logic w_req_err;
   logic r_err;
   logic r_resp_err;

   assign w_req_err = (req_addr[1:0] != 2'b00) ||
                      (req_addr[31:ADDR_WIDTH+2] != '0);
   assign w_acc_err = w_accept ? w_req_err : r_err;
   assign resp_err  = r_resp_err;

   // Error flag is captured at acceptance and presented with the response.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err      <= 1'b0;
         r_resp_err <= 1'b0;
      end else begin
         if (w_accept)
            r_err <= w_req_err;
         if (w_enter_resp)
            r_resp_err <= w_acc_err;
         else if (r_state == S_RESP)
            r_resp_err <= 1'b0;
      end
   end
`else
   // Byte-offset and upper address bits are deliberately ignored here.
   logic [31-ADDR_WIDTH:0] w_unused_addr;
   assign w_unused_addr = {req_addr[31:ADDR_WIDTH+2], req_addr[1:0]};
   assign w_acc_err     = 1'b0;
   assign resp_err      = 1'b0;
`endif

   // Next-state decode: IDLE accepts, WAIT counts down, RESP lasts one cycle.
   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_enter_resp = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (req_valid) begin
               w_accept = 1'b1;
               if (WAIT_VAL == 4'd0) begin
                  w_state_next = S_RESP;
                  w_enter_resp = 1'b1;
               end else begin
                  w_state_next = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (r_cnt == 4'd1) begin
               w_state_next = S_RESP;
               w_enter_resp = 1'b1;
            end
         end
         S_RESP:  w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // State, wait counter, latched request and registered load data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_write <= 1'b0;
         r_idx   <= '0;
         r_wdata <= 32'd0;
         r_rdata <= 32'd0;
      end else begin
         r_state <= w_state_next;
         if (w_accept) begin
            r_write <= req_write;
            r_idx   <= w_req_idx;
            r_wdata <= req_wdata;
            r_cnt   <= WAIT_VAL;
         end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (w_enter_resp) begin
            if (w_acc_write || w_acc_err)
               r_rdata <= 32'd0;
            else
               r_rdata <= r_mem[w_acc_idx];
         end else if (r_state == S_RESP) begin
            r_rdata <= 32'd0;
         end
      end
   end

   // A store lands on the edge entering RESP; an asserted reset suppresses it
   // so an interrupted store never reaches the array.
   assign w_mem_we = w_enter_resp && w_acc_write && !w_acc_err && !rst;

   // Storage array, not reset.
   always_ff @(posedge clk) begin
      if (w_mem_we)
         r_mem[w_acc_idx] <= w_acc_wdata;
   end

   assign req_ready  = (r_state == S_IDLE);
   assign resp_valid = (r_state == S_RESP);
   assign resp_rdata = r_rdata;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one instance with two wait states and one
// with zero wait states, sharing clock and reset.
module tb_dmem_responder;

   logic        clk;
   logic        rst;
   logic        req_valid  [2];
   logic        req_write  [2];
   logic [31:0] req_addr   [2];
   logic [31:0] req_wdata  [2];
   logic        req_ready  [2];
   logic        resp_valid [2];
   logic [31:0] resp_rdata [2];
   logic        resp_err   [2];

   int n_checks = 0;
   int n_errors = 0;

   dmem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(2)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid[0]),
      .req_write  (req_write[0]),
      .req_addr   (req_addr[0]),
      .req_wdata  (req_wdata[0]),
      .req_ready  (req_ready[0]),
      .resp_valid (resp_valid[0]),
      .resp_rdata (resp_rdata[0]),
      .resp_err   (resp_err[0])
   );

   dmem_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(0)) u_dut0 (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid[1]),
      .req_write  (req_write[1]),
      .req_addr   (req_addr[1]),
      .req_wdata  (req_wdata[1]),
      .req_ready  (req_ready[1]),
      .resp_valid (resp_valid[1]),
      .resp_rdata (resp_rdata[1]),
      .resp_err   (resp_err[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   // Issue one request on instance d, then check latency, response and the
   // return to IDLE. One line printed per transaction.
   task automatic do_req(input int d, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata,
                         input logic exp_err, input int exp_lat);
      int lat;
      @(negedge clk);
      req_valid[d] = 1'b1;
      req_write[d] = wr;
      req_addr[d]  = addr;
      req_wdata[d] = wdata;
      check("ready_before", 32'(req_ready[d]), 32'd1);
      @(posedge clk);
      #1 req_valid[d] = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!resp_valid[d] && lat < 20);
      check("latency", 32'(lat), 32'(exp_lat));
      check("resp_valid", 32'(resp_valid[d]), 32'd1);
      check("ready_in_resp", 32'(req_ready[d]), 32'd0);
      check("resp_rdata", resp_rdata[d], exp_rdata);
      check("resp_err", 32'(resp_err[d]), 32'(exp_err));
      $display("txn dut%0d %s addr=0x%08h wdata=0x%08h -> lat=%0d rdata=0x%08h err=%0d",
               d, wr ? "ST" : "LD", addr, wdata, lat, resp_rdata[d], resp_err[d]);
      @(negedge clk);
      check("valid_after", 32'(resp_valid[d]), 32'd0);
      check("ready_after", 32'(req_ready[d]), 32'd1);
      check("rdata_cleared", resp_rdata[d], 32'd0);
      check("err_cleared", 32'(resp_err[d]), 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      for (int d = 0; d < 2; d++) begin
         req_valid[d] = 1'b0;
         req_write[d] = 1'b0;
         req_addr[d]  = 32'd0;
         req_wdata[d] = 32'd0;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int d = 0; d < 2; d++) begin
         check("rst_ready", 32'(req_ready[d]), 32'd1);
         check("rst_valid", 32'(resp_valid[d]), 32'd0);
         check("rst_rdata", resp_rdata[d], 32'd0);
         check("rst_err", 32'(resp_err[d]), 32'd0);
      end

      // Store then load, two wait states.
      do_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 3);
      do_req(0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 3);

      // Reset in the middle of a store: no response and the word keeps its value.
      do_req(0, 1'b1, 32'h20, 32'h11111111, 32'h0, 1'b0, 3);
      @(negedge clk);
      req_valid[0] = 1'b1;
      req_write[0] = 1'b1;
      req_addr[0]  = 32'h20;
      req_wdata[0] = 32'h12345678;
      @(posedge clk);
      #1 req_valid[0] = 1'b0;
      @(negedge clk);
      check("midrst_in_wait", 32'(req_ready[0]), 32'd0);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("midrst_no_resp", 32'(resp_valid[0]), 32'd0);
         check("midrst_ready", 32'(req_ready[0]), 32'd1);
         @(negedge clk);
      end
      $display("txn dut0 reset during store to 0x00000020");
      do_req(0, 1'b0, 32'h20, 32'h0, 32'h11111111, 1'b0, 3);

      // Address checking versus wrap-around.
      do_req(0, 1'b1, 32'h0, 32'hCAFEF00D, 32'h0, 1'b0, 3);
`ifdef DMEM_RESP_ERR_EN
      do_req(0, 1'b1, 32'h402, 32'h55555555, 32'h0, 1'b1, 3);
      do_req(0, 1'b1, 32'h400, 32'h66666666, 32'h0, 1'b1, 3);
      do_req(0, 1'b1, 32'h2,   32'h77777777, 32'h0, 1'b1, 3);
      do_req(0, 1'b0, 32'h400, 32'h0, 32'h0, 1'b1, 3);
      do_req(0, 1'b0, 32'h0,   32'h0, 32'hCAFEF00D, 1'b0, 3);
`else
      do_req(0, 1'b1, 32'h400, 32'h0BADF00D, 32'h0, 1'b0, 3);
      do_req(0, 1'b0, 32'h0,   32'h0, 32'h0BADF00D, 1'b0, 3);
      do_req(0, 1'b0, 32'h402, 32'h0, 32'h0BADF00D, 1'b0, 3);
      do_req(0, 1'b0, 32'h10,  32'h0, 32'hDEADBEEF, 1'b0, 3);
`endif

      // Zero wait states: fill words 0..7, then read one back.
      for (int n = 0; n < 8; n++)
         do_req(1, 1'b1, 32'(4 * n), 32'hA0000000 + 32'(n), 32'h0, 1'b0, 1);
      do_req(1, 1'b0, 32'h8, 32'h0, 32'hA0000002, 1'b0, 1);

      // Handshake: req_valid held high with a new address every cycle. With zero
      // wait states the responder accepts every other cycle, so only the even
      // word addresses are serviced.
      for (int n = 0; n < 9; n++) begin
         @(negedge clk);
         if (n == 0) begin
            check("hs_ready", 32'(req_ready[1]), 32'd1);
            check("hs_valid", 32'(resp_valid[1]), 32'd0);
         end else begin
            check("hs_ready", 32'(req_ready[1]), (n % 2 == 0) ? 32'd1 : 32'd0);
            check("hs_valid", 32'(resp_valid[1]), (n % 2 == 1) ? 32'd1 : 32'd0);
            check("hs_rdata", resp_rdata[1],
                  (n % 2 == 1) ? (32'hA0000000 + 32'(n - 1)) : 32'd0);
            if (n % 2 == 1)
               $display("txn dut1 LD addr=0x%08h -> rdata=0x%08h (held valid)",
                        32'(4 * (n - 1)), resp_rdata[1]);
         end
         if (n < 8) begin
            req_valid[1] = 1'b1;
            req_write[1] = 1'b0;
            req_addr[1]  = 32'(4 * n);
         end else begin
            req_valid[1] = 1'b0;
         end
      end
      @(negedge clk);
      check("hs_idle_valid", 32'(resp_valid[1]), 32'd0);
      check("hs_idle_ready", 32'(req_ready[1]), 32'd1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Multi-cycle data-memory responder: the memory-side end of the CPU's load/store interface. It accepts one word request at a time through a valid/ready handshake, inserts a fixed number of wait states, then performs the read or write and returns a single-cycle response. It sits between the CPU's data-access port and a word-addressed storage array. It is the building block for moving the CPU off zero-latency data memory.

## Interface
- `ADDR_WIDTH`, default 8: word-index width; the array holds 2^ADDR_WIDTH 32-bit words (1 KiB at default).
- `WAIT_CYCLES`, default 2: wait states between request acceptance and access; legal range 0..15.

Ports:
- `clk` input, 1 bit: single clock; all state changes on its rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `req_valid` input, 1 bit: request present.
- `req_write` input, 1 bit: 1 = store, 0 = load.
- `req_addr` input, 32 bits: byte address.
- `req_wdata` input, 32 bits: store data.
- `req_ready` output, 1 bit: responder can accept a request.
- `resp_valid` output, 1 bit: one-cycle response strobe.
- `resp_rdata` output, 32 bits: load data, qualified by `resp_valid`.
- `resp_err` output, 1 bit: access rejected, qualified by `resp_valid`.

## Operation
- FSM states are IDLE, WAIT and RESP.
- `req_ready` is 1 only in IDLE and is a pure decode of the state.
- Acceptance happens on a rising edge with `req_valid && req_ready`.
  - On acceptance, latch `req_write`, `req_addr` and `req_wdata`, and load the counter with `WAIT_CYCLES`.
  - Go to WAIT if `WAIT_CYCLES > 0`, otherwise go directly to RESP.
- WAIT: decrement the counter each edge. On the edge where the counter equals 1, go to RESP.
- Access occurs on the edge that enters RESP.
  - Word index is `addr[ADDR_WIDTH+1:2]`.
  - Store: write the latched data to the array. `resp_rdata` is registered as 0.
  - Load: register the array word into `resp_rdata`.
- RESP: `resp_valid` is 1 for exactly one cycle, then the FSM returns to IDLE unconditionally. There is no response backpressure.
- On return to IDLE, `resp_rdata` and `resp_err` clear to 0.
- Read-after-write: a load sees every store whose response has already completed.
- `req_valid` while not in IDLE is ignored. The requester must hold the request until it is accepted.

## Timing
- Accept at edge E. `resp_valid` is high in the cycle following edge E+WAIT_CYCLES.
  - Latency is WAIT_CYCLES+1 cycles.
  - Minimum request-to-request period is WAIT_CYCLES+2 cycles.
- Reset values: state IDLE, counter 0, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0. Array contents are not reset.
- Reset mid-operation (WAIT or RESP): a pending store is discarded and the array is unchanged. No response is issued.
- Reset and acceptance on the same edge: reset wins and the request is dropped.
- Counter is 4 bits. `WAIT_CYCLES` > 15 is illegal and is rejected by elaboration check.

## Configuration
- Macro `DMEM_RESP_ERR_EN` controls access checking.
- With the macro defined: at acceptance, an address is flagged when `req_addr[1:0] != 0` (misaligned) or when `req_addr[31:ADDR_WIDTH+2] != 0` (out of range).
  - A flagged access proceeds through the same latency.
  - At RESP, `resp_err`=1 and `resp_rdata`=0, and a store does not modify the array.
- Without the macro: `resp_err` is tied to 0. `req_addr[1:0]` and the bits above the index are ignored, so out-of-range addresses wrap modulo the array size.

## Test plan
- Reset then idle: assert `rst` for 2 cycles -> `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0.
- Store then load (WAIT_CYCLES=2):
  - Store 0xDEADBEEF at 0x10 accepted at edge E -> `resp_valid` in the cycle after E+2 with `resp_rdata`=0.
  - Load 0x10 -> `resp_rdata`=0xDEADBEEF, `resp_err`=0.
- Zero wait (WAIT_CYCLES=0):
  - Load accepted at E -> `resp_valid` in the cycle after E+0 (the cycle after E).
  - `req_ready` low for exactly 1 cycle; back-to-back period is 2 cycles.
- Handshake: `req_valid` held high continuously with changing address -> only addresses presented while `req_ready`=1 are serviced, one response per acceptance.
- Reset mid-store: store 0x12345678 to 0x20 and assert `rst` during WAIT -> no `resp_valid`; a later load of 0x20 returns its prior value.
- Checking behaviour:
  - With `DMEM_RESP_ERR_EN`: store to 0x402 (misaligned) and to 0x400 (out of range, ADDR_WIDTH=8) -> `resp_err`=1 and the array is unchanged.
  - Without the macro: store to 0x400 -> lands in word 0, and a load of 0x0 returns the stored value.
